// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types for the external memory bus sequencer.
package bus_types;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} bus_state_t;

    // Pad strobe bundle, kept together so the idle/turnaround value is one constant.
    typedef struct packed {
        logic ale;
        logic nMe;
        logic nOe;
        logic rnW;
        logic enb;
    } strobes_t;

    localparam strobes_t STROBES_INACTIVE = '{
        ale: 1'b0,
        nMe: 1'b1,
        nOe: 1'b1,
        rnW: 1'b1,
        enb: 1'b0
    };

endpackage

// File: rtl/mem_bus_ctrl_wait_timer.sv
// Wait-state counter: clears on request, counts up while enabled, saturates at MaxWait.
module wait_timer #(
    parameter int unsigned CW       = 8,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic Clock,
    input  logic nReset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] countQ;

    // Counter register; clear wins over enable, never counts past MAX_WAIT.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            countQ <= '0;
        end else if (clear) begin
            countQ <= '0;
        end else if (enable && (countQ < CW'(MAX_WAIT))) begin
            countQ <= countQ + CW'(1);
        end
    end

    assign expired = (countQ == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequences one external memory cycle on the multiplexed address/data bus.
// All pad strobes and handshake outputs are registered from the next state.
module mem_bus_ctrl
    import bus_types::*;
#(
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CW       = 8
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic          MemReq,
    input  logic          MemRnW,
    input  logic [DW-1:0] Addr,
    input  logic [DW-1:0] WData,
    output logic          Ack,
    output logic          BusErr,
    output logic [DW-1:0] RData,
    output logic          Busy,
    output logic [DW-1:0] BusOut,
    input  logic [DW-1:0] BusIn,
    output logic          ALE,
    output logic          nME,
    output logic          nOE,
    output logic          RnW,
    output logic          ENB,
    input  logic          nWait
);

    bus_state_t    stateQ, stateD;
    logic [DW-1:0] addrQ, addrD, wdataQ, wdataD;
    logic          rnwQ, rnwD;
    strobes_t      strobesQ, strobesD;
    logic [DW-1:0] busOutQ, busOutD, rDataQ, rDataD;
    logic          ackQ, ackD, busErrQ, busErrD, busyQ, busyD;
    logic          timerClear, timerEnable, timerExpired;
    logic          reqAccept;

    wait_timer #(
        .CW       (CW),
        .MAX_WAIT (MAX_WAIT)
    ) u_waitTimer (
        .Clock   (Clock),
        .nReset  (nReset),
        .clear   (timerClear),
        .enable  (timerEnable),
        .expired (timerExpired)
    );

    assign reqAccept = (stateQ == IDLE) && MemReq;
    assign addrD     = reqAccept ? Addr   : addrQ;
    assign wdataD    = reqAccept ? WData  : wdataQ;
    assign rnwD      = reqAccept ? MemRnW : rnwQ;

    // Next-state logic and wait-timer control.
    always_comb begin
        stateD      = stateQ;
        timerClear  = 1'b0;
        timerEnable = 1'b0;
        case (stateQ)
            IDLE: if (MemReq) stateD = ADDR;
            ADDR: begin
                stateD     = DATA;
                timerClear = 1'b1;
            end
            DATA: begin
                if (nWait || timerExpired) stateD = DONE;
                else                       timerEnable = 1'b1;
            end
            DONE: stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Output values for the coming state; read data and error update only on leaving DATA.
    always_comb begin
        strobesD = STROBES_INACTIVE;
        busOutD  = '0;
        ackD     = 1'b0;
        busyD    = (stateD != IDLE);
        busErrD  = busErrQ;
        rDataD   = rDataQ;
        case (stateD)
            ADDR: begin
                strobesD.ale = 1'b1;
                strobesD.enb = 1'b1;
                busOutD      = addrD;
            end
            DATA: begin
                strobesD.nMe = 1'b0;
                if (rnwD) begin
                    strobesD.nOe = 1'b0;
                end else begin
                    strobesD.rnW = 1'b0;
                    strobesD.enb = 1'b1;
                    busOutD      = wdataD;
                end
            end
            DONE: ackD = 1'b1;
            default: ;
        endcase
        if ((stateQ == DATA) && (stateD == DONE)) begin
            busErrD = !nWait;
            if (nWait && rnwQ) rDataD = BusIn;
        end
    end

    // State, latched request and registered outputs; reset aborts any cycle silently.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            stateQ   <= IDLE;
            addrQ    <= '0;
            wdataQ   <= '0;
            rnwQ     <= 1'b1;
            strobesQ <= STROBES_INACTIVE;
            busOutQ  <= '0;
            rDataQ   <= '0;
            ackQ     <= 1'b0;
            busErrQ  <= 1'b0;
            busyQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            addrQ    <= addrD;
            wdataQ   <= wdataD;
            rnwQ     <= rnwD;
            strobesQ <= strobesD;
            busOutQ  <= busOutD;
            rDataQ   <= rDataD;
            ackQ     <= ackD;
            busErrQ  <= busErrD;
            busyQ    <= busyD;
        end
    end

    assign ALE    = strobesQ.ale;
    assign nME    = strobesQ.nMe;
    assign nOE    = strobesQ.nOe;
    assign RnW    = strobesQ.rnW;
    assign ENB    = strobesQ.enb;
    assign BusOut = busOutQ;
    assign RData  = rDataQ;
    assign Ack    = ackQ;
    assign BusErr = busErrQ;
    assign Busy   = busyQ;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: driver pushes expected completions, monitor pops on Ack.
module tb_mem_bus_ctrl;

    localparam int MaxWait = 15;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        MemReq = 1'b0;
    logic        MemRnW = 1'b1;
    logic [15:0] Addr = '0;
    logic [15:0] WData = '0;
    logic [15:0] BusIn = '0;
    logic        nWait = 1'b1;
    logic        Ack, BusErr, Busy, ALE, nME, nOE, RnW, ENB;
    logic [15:0] RData, BusOut;

    mem_bus_ctrl #(
        .DW       (16),
        .MAX_WAIT (MaxWait),
        .CW       (8)
    ) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .MemReq (MemReq),
        .MemRnW (MemRnW),
        .Addr   (Addr),
        .WData  (WData),
        .Ack    (Ack),
        .BusErr (BusErr),
        .RData  (RData),
        .Busy   (Busy),
        .BusOut (BusOut),
        .BusIn  (BusIn),
        .ALE    (ALE),
        .nME    (nME),
        .nOE    (nOE),
        .RnW    (RnW),
        .ENB    (ENB),
        .nWait  (nWait)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          ackCyc;
        logic        err;
        logic [15:0] rdata;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rnw;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          lastAck = -10;
    int          curWaits = 0;
    logic [15:0] curBusIn = '0;
    int          dataCycles = 0;
    logic [15:0] modelRData = '0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: stretches the cycle by curWaits, then presents read data.
    always @(negedge Clock) begin
        if (nReset && !nME) begin
            nWait = (dataCycles < curWaits) ? 1'b0 : 1'b1;
            BusIn = (dataCycles == curWaits) ? curBusIn : 16'($urandom);
            dataCycles++;
        end else begin
            dataCycles = 0;
            nWait = 1'($urandom_range(0, 1));
            BusIn = 16'($urandom);
        end
    end

    // Monitor: bus invariants, strobes against the in-flight request, completions.
    always @(negedge Clock) begin
        if (nReset) begin
            check("enb_noe_overlap", {31'd0, ENB && !nOE}, 32'd0);
            check("ale_nme_overlap", {31'd0, ALE && !nME}, 32'd0);
            if (sbq.size() > 0) begin
                if (ALE) check("addr_phase_busout", {16'd0, BusOut}, {16'd0, sbq[0].addr});
                if (!nME) begin
                    check("data_rnw", {31'd0, RnW}, {31'd0, sbq[0].rnw});
                    if (sbq[0].rnw) begin
                        check("read_noe", {31'd0, nOE}, 32'd0);
                        check("read_enb", {31'd0, ENB}, 32'd0);
                    end else begin
                        check("write_enb", {31'd0, ENB}, 32'd1);
                        check("write_busout", {16'd0, BusOut}, {16'd0, sbq[0].wdata});
                    end
                end
            end
            if (Ack) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got Ack=1 expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("ack_cycle", cyc, e.ackCyc);
                    check("bus_err", {31'd0, BusErr}, {31'd0, e.err});
                    check("rdata", {16'd0, RData}, {16'd0, e.rdata});
                    check("busy_at_ack", {31'd0, Busy}, 32'd1);
                end
            end
        end
    end

    // One transaction; returns at the negedge where Ack is seen with MemReq still high.
    task automatic doTxn(input logic rnw, input logic [15:0] a, input logic [15:0] wd,
                         input int waits, input logic [15:0] bi, input int gap,
                         input bit scramble);
        exp_t e;
        int   t0;
        int   k;
        bit   err;
        if (gap > 0) begin
            MemReq = 1'b0;
            repeat (gap) @(negedge Clock);
        end
        MemReq   = 1'b1;
        MemRnW   = rnw;
        Addr     = a;
        WData    = wd;
        curWaits = waits;
        curBusIn = bi;
        t0 = (cyc > lastAck + 1) ? cyc : lastAck + 1;
        err = (waits > MaxWait);
        if (!err && rnw) modelRData = bi;
        e.ackCyc = t0 + (err ? MaxWait + 3 : waits + 3);
        e.err    = err;
        e.rdata  = modelRData;
        e.addr   = a;
        e.wdata  = wd;
        e.rnw    = rnw;
        sbq.push_back(e);
        for (k = 0; k < 40; k++) begin
            @(negedge Clock);
            if (Ack) break;
            if (scramble && cyc > t0) begin
                Addr   = 16'($urandom);
                WData  = 16'($urandom);
                MemRnW = 1'($urandom_range(0, 1));
            end
        end
        if (k == 40) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no Ack expected one by cycle %0d", e.ackCyc);
            sbq.delete();
        end
        lastAck = cyc;
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_ale"}, {31'd0, ALE}, 32'd0);
        check({tag, "_nme"}, {31'd0, nME}, 32'd1);
        check({tag, "_noe"}, {31'd0, nOE}, 32'd1);
        check({tag, "_rnw"}, {31'd0, RnW}, 32'd1);
        check({tag, "_enb"}, {31'd0, ENB}, 32'd0);
        check({tag, "_busout"}, {16'd0, BusOut}, 32'd0);
        check({tag, "_ack"}, {31'd0, Ack}, 32'd0);
        check({tag, "_buserr"}, {31'd0, BusErr}, 32'd0);
        check({tag, "_rdata"}, {16'd0, RData}, 32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge Clock);
        checkIdleOutputs("reset");
        nReset = 1'b1;

        // Directed cases: plain read, stretched write with moving inputs, timeouts.
        doTxn(1'b1, 16'h0123, 16'h0000, 0, 16'hBEEF, 1, 1'b0);
        doTxn(1'b0, 16'h0040, 16'h5A5A, 3, 16'h1111, 1, 1'b1);
        doTxn(1'b1, 16'h0200, 16'h0000, 30, 16'h2222, 1, 1'b0);
        doTxn(1'b1, 16'h0201, 16'h0000, 0, 16'h3333, 0, 1'b0);
        doTxn(1'b1, 16'h0300, 16'h0000, MaxWait, 16'h4444, 1, 1'b1);
        doTxn(1'b0, 16'h0301, 16'hA5A5, MaxWait + 1, 16'h5555, 1, 1'b0);

        // Back-to-back reads with MemReq held high.
        doTxn(1'b1, 16'h1000, 16'h0000, 0, 16'h6001, 2, 1'b0);
        doTxn(1'b1, 16'h1001, 16'h0000, 0, 16'h6002, 0, 1'b0);
        doTxn(1'b1, 16'h1002, 16'h0000, 0, 16'h6003, 0, 1'b0);

        // Reset while a write is in its data phase.
        MemReq = 1'b0;
        repeat (2) @(negedge Clock);
        MemReq   = 1'b1;
        MemRnW   = 1'b0;
        Addr     = 16'h0777;
        WData    = 16'hC3C3;
        curWaits = 5;
        t0 = cyc;
        while (cyc < t0 + 3 && cyc < t0 + 40) @(negedge Clock);
        check("rst_in_data_nme", {31'd0, nME}, 32'd0);
        check("rst_in_data_rnw", {31'd0, RnW}, 32'd0);
        nReset = 1'b0;
        MemReq = 1'b0;
        @(negedge Clock);
        checkIdleOutputs("midreset");
        modelRData = '0;
        nReset = 1'b1;
        repeat (6) @(negedge Clock);
        doTxn(1'b0, 16'h0778, 16'h3C3C, 1, 16'h7777, 1, 1'b0);
        doTxn(1'b1, 16'h0779, 16'h0000, 2, 16'h8888, 1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            doTxn(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, MaxWait + 2)), 16'($urandom),
                  int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        MemReq = 1'b0;
        repeat (8) @(negedge Clock);
        check("scoreboard_drained", sbq.size(), 32'd0);
        check("idle_busy", {31'd0, Busy}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected $finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
